// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared video timing definitions for the scan-out path.
//   - 640x480@60 timing constants, used as parameter defaults
//   - total(): line/frame length from the four timing segments
//   - scan_flags_t: per-pixel timing flags carried down the scan pipeline
// ----------------------------------------------------------------------------
package video_pkg;

    localparam int   VID_H_ACTIVE   = 640;
    localparam int   VID_H_FP       = 16;
    localparam int   VID_H_SYNC     = 96;
    localparam int   VID_H_BP       = 48;
    localparam int   VID_V_ACTIVE   = 480;
    localparam int   VID_V_FP       = 10;
    localparam int   VID_V_SYNC     = 2;
    localparam int   VID_V_BP       = 33;
    localparam logic VID_SYNC_LEVEL = 1'b0;

    // Timing flags of one counter position: inside the visible window,
    // inside the horizontal sync pulse, inside the vertical sync pulse.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } scan_flags_t;

    function automatic int total(input int active, input int fp,
                                 input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/frame_bit_ram.sv
// ----------------------------------------------------------------------------
// frame_bit_ram
// Two-bank, 1-bit wide simple dual-port frame store. One write port and one
// registered read port, both advancing only when ce=1. The MSB of each
// address selects the bank; the lower ADDR_W bits address a pixel inside the
// bank. Each bank holds BANK_DEPTH pixels, so the array is 2*BANK_DEPTH deep.
//
// Ports:
//   clk      in   system clock
//   ce       in   clock enable for both ports
//   wr_en    in   write strobe (caller guarantees an in-range address)
//   wr_addr  in   {bank, pixel} write address
//   wr_data  in   write data
//   rd_addr  in   {bank, pixel} read address
//   rd_data  out  registered read data, one ce cycle after rd_addr
// ----------------------------------------------------------------------------
module frame_bit_ram #(
    parameter int BANK_DEPTH = 307200,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic              wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic              rd_data
);

    localparam int DEPTH = 2 * BANK_DEPTH;
    localparam int IDX_W = $clog2(DEPTH);

    logic mem [DEPTH];

    // Packs the two banks back to back instead of spacing them a power of
    // two apart, so no storage is wasted when BANK_DEPTH is not 2**ADDR_W.
    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W:0] a);
        logic [IDX_W-1:0] low;
        low = IDX_W'(a[ADDR_W-1:0]);
        return a[ADDR_W] ? (low + IDX_W'(BANK_DEPTH)) : low;
    endfunction

    always_ff @(posedge clk) begin
        if (ce) begin
            if (wr_en) begin
                mem[to_index(wr_addr)] <= wr_data;
            end
            rd_data <= mem[to_index(rd_addr)];
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// ----------------------------------------------------------------------------
// frame_scanout
// Double-buffered 1-bit frame store with VGA-style scan-out. The renderer
// writes into the back bank while the front bank is streamed out. At the
// start of vertical blanking the banks flip and a one-ce-period swap strobe
// releases the renderer for the next frame.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   ce         in   pixel clock enable; all state advances only when ce=1
//   wr_en      in   renderer pixel write strobe
//   wr_addr    in   linear pixel address y*HOR_ACTIVE_PIXELS+x
//   wr_data    in   pixel value
//   swap       out  one-ce-period strobe at vblank start
//   hsync      out  horizontal sync
//   vsync      out  vertical sync
//   de         out  active-video data enable
//   pixel      out  scanned-out pixel, 0 whenever de=0
//   front_sel  out  bank currently displayed
//
// Output timing is the counter state two ce cycles earlier:
//   stage 1: RAM read address {front_sel, rd_addr} and timing flags
//   stage 2: RAM read data and delayed flags (de/hsync/vsync registers)
// ----------------------------------------------------------------------------
module frame_scanout
    import video_pkg::*;
#(
    parameter int   HOR_ACTIVE_PIXELS = VID_H_ACTIVE,
    parameter int   VER_ACTIVE_PIXELS = VID_V_ACTIVE,
    parameter int   HOR_FRONT_PORCH   = VID_H_FP,
    parameter int   HOR_SYNC_PULSE    = VID_H_SYNC,
    parameter int   HOR_BACK_PORCH    = VID_H_BP,
    parameter int   VER_FRONT_PORCH   = VID_V_FP,
    parameter int   VER_SYNC_PULSE    = VID_V_SYNC,
    parameter int   VER_BACK_PORCH    = VID_V_BP,
    parameter logic SYNC_ACTIVE_LEVEL = VID_SYNC_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic wr_en,
    input  logic [$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)-1:0] wr_addr,
    input  logic wr_data,
    output logic swap,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic pixel,
    output logic front_sel
);

    localparam int H_TOTAL = total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                   HOR_SYNC_PULSE, HOR_BACK_PORCH);
    localparam int V_TOTAL = total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                   VER_SYNC_PULSE, VER_BACK_PORCH);
    localparam int NPIX    = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int AW      = $clog2(NPIX);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int HS_END   = HS_START + HOR_SYNC_PULSE;
    localparam int VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int VS_END   = VS_START + VER_SYNC_PULSE;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FLIP = VW'(VER_ACTIVE_PIXELS - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] rd_addr;

    int            h_i;
    int            v_i;
    scan_flags_t   cur_flags;
    logic          line_end;
    logic          frame_end;
    logic          flip_now;
    logic          wr_in_range;

    scan_flags_t   s1_flags;
    logic [AW:0]   s1_addr;
    logic          ram_q;

    always_comb begin
        h_i           = int'(h_cnt);
        v_i           = int'(v_cnt);
        cur_flags     = '0;
        cur_flags.act = (h_i < HOR_ACTIVE_PIXELS) && (v_i < VER_ACTIVE_PIXELS);
        cur_flags.hs  = (h_i >= HS_START) && (h_i < HS_END);
        cur_flags.vs  = (v_i >= VS_START) && (v_i < VS_END);
        line_end      = (h_cnt == H_LAST);
        frame_end     = line_end && (v_cnt == V_LAST);
        // Last position before (0, VER_ACTIVE_PIXELS): the edge leaving it
        // is the start of vertical blanking.
        flip_now      = line_end && (v_cnt == V_FLIP);
        wr_in_range   = (int'(wr_addr) < NPIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            rd_addr   <= '0;
            front_sel <= 1'b0;
            swap      <= 1'b0;
            s1_flags  <= '0;
            s1_addr   <= '0;
            de        <= 1'b0;
            hsync     <= ~SYNC_ACTIVE_LEVEL;
            vsync     <= ~SYNC_ACTIVE_LEVEL;
        end else if (ce) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // Linear address follows the raster without a y*width product.
            if (frame_end) begin
                rd_addr <= '0;
            end else if (cur_flags.act) begin
                rd_addr <= rd_addr + 1'b1;
            end

            if (flip_now) begin
                front_sel <= ~front_sel;
            end
            swap <= flip_now;

            s1_flags <= cur_flags;
            s1_addr  <= {front_sel, rd_addr};

            de    <= s1_flags.act;
            hsync <= s1_flags.hs ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            vsync <= s1_flags.vs ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
        end
    end

    // Writes target the bank not being displayed. A write on the flip edge
    // still sees the old front_sel, so it lands in the bank becoming front.
    frame_bit_ram #(
        .BANK_DEPTH (NPIX),
        .ADDR_W     (AW)
    ) u_ram (
        .clk     (clk),
        .ce      (ce),
        .wr_en   (wr_en && wr_in_range),
        .wr_addr ({~front_sel, wr_addr}),
        .wr_data (wr_data),
        .rd_addr (s1_addr),
        .rd_data (ram_q)
    );

    // RAM contents are never reset; masking with de keeps blanking clean.
    assign pixel = ram_q & de;

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
Downstream neighbour of the frame renderer. Receives its 1-bit pixel writes (wr_en/wr_addr/wr_data) into the back half of a double-buffered frame store. Scans the front half out as a VGA-style stream (hsync, vsync, de, pixel). Issues the swap strobe that releases the renderer from its DONE state, and flips the buffers at the start of vertical blanking.

Parameters:
HOR_ACTIVE_PIXELS, 640, visible pixels per line
VER_ACTIVE_PIXELS, 480, visible lines per frame
HOR_FRONT_PORCH, 16, pixels
HOR_SYNC_PULSE, 96, pixels
HOR_BACK_PORCH, 48, pixels
VER_FRONT_PORCH, 10, lines
VER_SYNC_PULSE, 2, lines
VER_BACK_PORCH, 33, lines
SYNC_ACTIVE_LEVEL, 0, level of hsync/vsync during the pulse

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ce  in  1  pixel clock enable; all state advances only when ce=1
wr_en  in  1  renderer pixel write strobe
wr_addr  in  clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)  linear address, y*HOR_ACTIVE_PIXELS+x
wr_data  in  1  pixel value
swap  out  1  one-ce-period strobe at vblank start; renderer's frame-release input
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  active-video data enable
pixel  out  1  scanned-out pixel, 0 whenever de=0
front_sel  out  1  bank currently displayed (debug/verification)

Behaviour:
- Clock is clk; reset is synchronous and active-high, named rst. Every state element updates only on posedge clk with ce=1, except reset.
- Reset values: h_cnt=0, v_cnt=0, rd_addr=0, front_sel=0, swap=0, de=0, pixel=0, hsync=vsync=~SYNC_ACTIVE_LEVEL. Frame RAM contents are not reset. Reset mid-frame restarts the frame at (0,0) on the next ce.
- Totals: H_TOTAL = sum of the four horizontal parameters; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Active region: h_cnt<HOR_ACTIVE_PIXELS and v_cnt<VER_ACTIVE_PIXELS.
- hsync pulse: HOR_ACTIVE+HFP <= h_cnt < HOR_ACTIVE+HFP+HSYNC.
- vsync pulse: the same rule applied to v_cnt.
- Read address: rd_addr is an incrementing counter, advanced once per active pixel and cleared when (h_cnt,v_cnt) = (H_TOTAL-1,V_TOTAL-1). No multiplier is used.
- Pipeline, fixed latency of 2 ce cycles:
  - stage 1 registers the RAM read address {front_sel, rd_addr} plus the active/hsync/vsync flags;
  - stage 2 holds the registered RAM output and the delayed flags.
  - Outputs are therefore exactly the timing of the counter state 2 ce-cycles earlier.
- Writes: when ce=1 and wr_en=1 and wr_addr < HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS, RAM[{~front_sel, wr_addr}] <= wr_data.
  - Out-of-range addresses are dropped silently.
  - Writes with ce=0 are ignored.
- Flip:
  - On the ce edge where the counters move to (h_cnt=0, v_cnt=VER_ACTIVE_PIXELS), front_sel toggles and swap is set to 1.
  - swap clears on the next ce edge, so it is high for exactly one ce-enabled cycle.
- Simultaneous write and flip: the write uses the pre-flip front_sel, i.e. it lands in the bank that is becoming front.
- Renderer contract (fixed, not checked): the renderer finishes drawing within one frame period. Otherwise the partially drawn bank is displayed.
- Active pixels displayed after a flip come from the new front bank only. The first visible pixel after a flip is pixel 0 of that bank.
- RAM: one simple dual-port, 2*HOR*VER x 1 bit, registered read, no read-during-write hazard between ports because they address different banks.

Decomposition:
- Shared package video_pkg holds the 640x480@60 timing constants used as parameter defaults and a function total(active, fp, sync, bp).
- One sub-module, frame_bit_ram: parameterised depth, 1-bit data, one write port and one registered read port, both gated by ce. The bank bit is the MSB of each address.
- Counters, sync generation, pipeline and flip logic stay in frame_scanout.

Test Plan:
1. Reset held 3 cycles with ce=1 -> hsync=vsync=1, de=0, pixel=0, swap=0, front_sel=0. After release, the first hsync low starts 2+656 ce cycles later and lasts 96.
2. Default params, ce=1 continuously -> line period 800 ce cycles, frame 525 lines, vsync low for 2 lines starting line 490, de high for 640x480 per frame.
3. Swap strobe -> one swap pulse per frame, 1 ce wide, coinciding with the front_sel toggle at (0,480). With ce toggling 1/0 every clk, swap spans 2 clk.
4. Write 1 to addresses 0, 639 and 307199 of the back bank, others 0; run to the flip -> the next frame shows pixel=1 at its first de cycle, at the last de cycle of line 0, and at the final de cycle. All other de cycles are 0.
5. Mid-frame writes of all-1s to the back bank -> the displayed frame is unchanged until the next flip. Writes to addr 307200 never appear.
6. Small sim config (HOR 8, VER 4, porches/syncs 1) with ce held low for 5 cycles mid-line -> all outputs freeze, and timing resumes exactly where it stopped.
